// File: rtl/seg_scan_ctrl_if.sv
// Display-content bus of the multiplexed seven-segment scanner: new contents in,
// per-digit drive and status pulses out.
interface seg_scan_ctrl_if;
    logic        load;
    logic [31:0] value;
    logic [7:0]  dp_mask;
    logic        blank_lz;
    logic [7:0]  dig;
    logic [3:0]  num;
    logic        dp_n;
    logic        upd_ack;
    logic        frame_tick;

    modport master (
        output load, value, dp_mask, blank_lz,
        input  dig, num, dp_n, upd_ack, frame_tick
    );

    modport slave (
        input  load, value, dp_mask, blank_lz,
        output dig, num, dp_n, upd_ack, frame_tick
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed display scanner with double-buffered contents that
// switch only on frame boundaries, dead-time blanking and leading-zero blanking.
module seg_scan_ctrl #(
    parameter int CLK_DIV = 100000,
    parameter int DEAD    = 1000
) (
    input logic            clk,
    input logic            rst,
    seg_scan_ctrl_if.slave bus
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] LAST   = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] DEAD_V = PW'(DEAD);

    logic [PW-1:0] pcnt;
    logic [2:0]    idx;
    logic [31:0]   shd_val, act_val;
    logic [7:0]    shd_dp, act_dp;
    logic          shd_blz, act_blz;
    logic          pending;
    logic [7:0]    dig_p1;
    logic [3:0]    num_p1;
    logic          dp_n_p1, upd_ack_p1, frame_tick_p1;

    logic          dwell_end, frame_end, off;
    logic [7:0]    lz_mask;

    // Bit k set when digit k sits in the run of leading zeros (digit 0 never does).
    function automatic logic [7:0] lz_blank_mask(input logic [31:0] v, input logic en);
        logic [7:0] m;
        logic       nz;
        m  = '0;
        nz = 1'b0;
        for (int k = 7; k >= 1; k--) begin
            nz   = nz | (v[4*k +: 4] != 4'd0);
            m[k] = en & ~nz;
        end
        return m;
    endfunction

    always_comb begin
        dwell_end = (pcnt == LAST);
        frame_end = dwell_end && (idx == 3'd7);
        lz_mask   = lz_blank_mask(act_val, act_blz);
        off       = (pcnt < DEAD_V) || lz_mask[idx];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pcnt          <= '0;
            idx           <= '0;
            shd_val       <= '0;
            shd_dp        <= '0;
            shd_blz       <= 1'b0;
            act_val       <= '0;
            act_dp        <= '0;
            act_blz       <= 1'b0;
            pending       <= 1'b0;
            dig_p1        <= 8'hFF;
            num_p1        <= '0;
            dp_n_p1       <= 1'b1;
            upd_ack_p1    <= 1'b0;
            frame_tick_p1 <= 1'b0;
        end else begin
            pcnt <= dwell_end ? '0 : pcnt + PW'(1);
            if (dwell_end)
                idx <= idx + 3'd1;

            if (bus.load) begin
                shd_val <= bus.value;
                shd_dp  <= bus.dp_mask;
                shd_blz <= bus.blank_lz;
            end

            // A load landing on the frame boundary bypasses the shadow set.
            upd_ack_p1 <= 1'b0;
            if (frame_end) begin
                if (bus.load) begin
                    act_val    <= bus.value;
                    act_dp     <= bus.dp_mask;
                    act_blz    <= bus.blank_lz;
                    upd_ack_p1 <= 1'b1;
                end else if (pending) begin
                    act_val    <= shd_val;
                    act_dp     <= shd_dp;
                    act_blz    <= shd_blz;
                    upd_ack_p1 <= 1'b1;
                end
                pending <= 1'b0;
            end else if (bus.load) begin
                pending <= 1'b1;
            end

            // output register stage p1
            frame_tick_p1 <= frame_end;
            dig_p1        <= off ? 8'hFF : ~(8'b1 << idx);
            num_p1        <= act_val[{idx, 2'b00} +: 4];
            dp_n_p1       <= off | ~act_dp[idx];
        end
    end

    assign bus.dig        = dig_p1;
    assign bus.num        = num_p1;
    assign bus.dp_n       = dp_n_p1;
    assign bus.upd_ack    = upd_ack_p1;
    assign bus.frame_tick = frame_tick_p1;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: cycle-level reference model, table of display probes,
// hand sequences for frame-boundary loads and mid-frame reset, randomized loads.
module tb_seg_scan_ctrl;
    localparam int CD = 8;
    localparam int DT = 2;
    localparam int FR = CD * 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    seg_scan_ctrl_if bus();

    seg_scan_ctrl #(.CLK_DIV(CD), .DEAD(DT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: position in the scan derived from a cycle count.
    int          m_t;
    logic [31:0] a_val, s_val;
    logic [7:0]  a_dp, s_dp;
    logic        a_blz, s_blz, m_pend;
    logic [7:0]  e_dig;
    logic [3:0]  e_num;
    logic        e_dpn, e_ack, e_tick;

    always @(posedge clk) begin : model
        int p, k;
        logic fe, off;
        logic [31:0] above;
        if (!rst) begin
            m_t = 0; a_val = 0; s_val = 0; a_dp = 0; s_dp = 0;
            a_blz = 0; s_blz = 0; m_pend = 0;
            e_dig = 8'hFF; e_num = 0; e_dpn = 1; e_ack = 0; e_tick = 0;
        end else begin
            p     = m_t % CD;
            k     = (m_t / CD) % 8;
            fe    = (p == CD - 1) && (k == 7);
            above = a_val >> (4 * k);
            off   = (p < DT) || (a_blz && k > 0 && above == 0);
            e_dig  = off ? 8'hFF : ~(8'(1) << k);
            e_num  = above[3:0];
            e_dpn  = off || !a_dp[k];
            e_tick = fe;
            e_ack  = fe && (bus.load || m_pend);
            if (fe) begin
                if (bus.load) begin
                    a_val = bus.value; a_dp = bus.dp_mask; a_blz = bus.blank_lz;
                end else if (m_pend) begin
                    a_val = s_val; a_dp = s_dp; a_blz = s_blz;
                end
                m_pend = 0;
            end else if (bus.load) begin
                m_pend = 1;
            end
            if (bus.load) begin
                s_val = bus.value; s_dp = bus.dp_mask; s_blz = bus.blank_lz;
            end
            m_t++;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock; outputs are sampled on the falling edge and scored against the model.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        chk("sb_dig",  32'(bus.dig),        32'(e_dig));
        chk("sb_num",  32'(bus.num),        32'(e_num));
        chk("sb_dpn",  32'(bus.dp_n),       32'(e_dpn));
        chk("sb_ack",  32'(bus.upd_ack),    32'(e_ack));
        chk("sb_tick", 32'(bus.frame_tick), 32'(e_tick));
    endtask

    task automatic do_load(input logic [31:0] v, input logic [7:0] dp, input logic blz);
        bus.value = v; bus.dp_mask = dp; bus.blank_lz = blz; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
    endtask

    task automatic wait_ack(input int bound);
        int n;
        n = 0;
        while (!bus.upd_ack && n < bound) begin
            step();
            n++;
        end
        chk("ack_timeout", 32'(bus.upd_ack), 32'd1);
    endtask

    task automatic wait_phase(input int ph);
        int n;
        n = 0;
        while ((m_t % FR) != ph && n < FR + 2) begin
            step();
            n++;
        end
        chk("phase_timeout", 32'(m_t % FR), 32'(ph));
    endtask

    typedef struct {
        logic [31:0] val;
        logic [7:0]  dp;
        logic        blz;
        int          k;
        logic [7:0]  dig;
        logic [3:0]  num;
        logic        dpn;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int n, acks, bad;
        logic [31:0] rv;
        vecs[0]  = '{32'h8765_4321, 8'h02, 1'b0, 1, 8'hFD, 4'h2, 1'b0};
        vecs[1]  = '{32'h8765_4321, 8'h02, 1'b0, 0, 8'hFE, 4'h1, 1'b1};
        vecs[2]  = '{32'h0000_0305, 8'h00, 1'b1, 2, 8'hFB, 4'h3, 1'b1};
        vecs[3]  = '{32'h0000_0305, 8'h00, 1'b1, 1, 8'hFD, 4'h0, 1'b1};
        vecs[4]  = '{32'h0000_0305, 8'h00, 1'b1, 3, 8'hFF, 4'h0, 1'b1};
        vecs[5]  = '{32'h0000_0000, 8'h00, 1'b1, 0, 8'hFE, 4'h0, 1'b1};
        vecs[6]  = '{32'h0000_0000, 8'h00, 1'b1, 1, 8'hFF, 4'h0, 1'b1};
        vecs[7]  = '{32'h00A0_0000, 8'h80, 1'b1, 5, 8'hDF, 4'hA, 1'b1};
        vecs[8]  = '{32'h00A0_0000, 8'h80, 1'b1, 7, 8'hFF, 4'h0, 1'b1};
        vecs[9]  = '{32'h00A0_0000, 8'h80, 1'b0, 7, 8'h7F, 4'h0, 1'b0};
        vecs[10] = '{32'hFFFF_FFFF, 8'hFF, 1'b1, 6, 8'hBF, 4'hF, 1'b0};

        bus.load = 1'b0; bus.value = '0; bus.dp_mask = '0; bus.blank_lz = 1'b0;
        rst = 1'b0;
        step();
        step();
        chk("rst_dig",  32'(bus.dig),        32'hFF);
        chk("rst_num",  32'(bus.num),        32'h0);
        chk("rst_dpn",  32'(bus.dp_n),       32'h1);
        chk("rst_ack",  32'(bus.upd_ack),    32'h0);
        chk("rst_tick", 32'(bus.frame_tick), 32'h0);

        // Dead time right after release, then digit 0 lit, then digit 1.
        rst = 1'b1;
        step(); chk("rel_dig0", 32'(bus.dig), 32'hFF);
        step(); chk("rel_dig1", 32'(bus.dig), 32'hFF);
        step(); chk("rel_dig2", 32'(bus.dig), 32'hFE);
        for (int i = 0; i < CD; i++) step();
        chk("dig1_lit", 32'(bus.dig), 32'hFD);

        // frame_tick period and no spurious upd_ack.
        n = 0; acks = 0;
        while (!bus.frame_tick && n < 2 * FR) begin step(); n++; acks += bus.upd_ack; end
        chk("tick_first", 32'(bus.frame_tick), 32'd1);
        n = 0;
        do begin step(); n++; acks += bus.upd_ack; end while (!bus.frame_tick && n < 2 * FR);
        chk("tick_period", 32'(n), 32'(FR));
        chk("no_ack_idle", 32'(acks), 32'd0);

        // Table of display probes.
        foreach (vecs[i]) begin
            wait_phase(20);
            do_load(vecs[i].val, vecs[i].dp, vecs[i].blz);
            chk("no_early_ack", 32'(bus.upd_ack), 32'd0);
            wait_ack(2 * FR);
            for (int s = 0; s < CD * vecs[i].k + DT + 1; s++) step();
            chk($sformatf("vec%0d_dig", i), 32'(bus.dig),  32'(vecs[i].dig));
            chk($sformatf("vec%0d_num", i), 32'(bus.num),  32'(vecs[i].num));
            chk($sformatf("vec%0d_dpn", i), 32'(bus.dp_n), 32'(vecs[i].dpn));
        end

        // Load on the frame-end cycle: immediate transfer, nothing left pending.
        wait_phase(FR - 1);
        do_load(32'h1111_1111, 8'h00, 1'b0);
        chk("fe_load_ack", 32'(bus.upd_ack), 32'd1);
        acks = 0;
        for (int s = 0; s < FR + 6; s++) begin step(); acks += bus.upd_ack; end
        chk("fe_load_no_second_ack", 32'(acks), 32'd0);

        // Two loads in one frame: only the second shows, one ack.
        wait_phase(8);
        do_load(32'h2222_2222, 8'h00, 1'b0);
        step(); step();
        do_load(32'h3333_3333, 8'h00, 1'b0);
        wait_ack(2 * FR);
        step(); step(); step();
        chk("last_wins_num", 32'(bus.num), 32'h3);
        acks = 0;
        for (int s = 0; s < FR; s++) begin step(); acks += bus.upd_ack; end
        chk("last_wins_one_ack", 32'(acks), 32'd0);

        // Reset during digit 4 with content pending: content is discarded.
        wait_phase(5);
        do_load(32'h9999_9999, 8'hFF, 1'b0);
        wait_phase(4 * CD + 2);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("mid_rst_dig",  32'(bus.dig),     32'hFF);
        chk("mid_rst_num",  32'(bus.num),     32'h0);
        chk("mid_rst_dpn",  32'(bus.dp_n),    32'h1);
        chk("mid_rst_ack",  32'(bus.upd_ack), 32'h0);
        acks = 0; bad = 0;
        for (int s = 0; s < 2 * FR + 4; s++) begin
            step();
            acks += bus.upd_ack;
            if (bus.num != 4'h0 || bus.dp_n != 1'b1 && bus.dig == 8'hFF) bad++;
        end
        chk("mid_rst_no_ack", 32'(acks), 32'd0);
        chk("mid_rst_zeros",  32'(bad),  32'd0);
        chk("mid_rst_restart_dig", 32'(bus.dig), 32'(e_dig));

        // Randomized loads, including frame-end coincidences and rare resets.
        for (int s = 0; s < 2500; s++) begin
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b0; step(); rst = 1'b1;
            end else if ($urandom_range(0, 19) == 0 ||
                         ((m_t % FR) == FR - 1 && $urandom_range(0, 2) == 0)) begin
                rv = $urandom;
                rv = rv >> $urandom_range(0, 32);
                do_load(rv, 8'($urandom), 1'($urandom));
            end else begin
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
